// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add unsigned multiplier (N x N -> 2N) driving an external 16-bit adder
// Ports: clk_i/rst_i (sync active-high); start_i, a_i, b_i request; busy_o, done_o, result_o, ovf_o status;
// add_high_o/add_not_high_o/add_low_o/add_not_low_o/add_c_o/add_not_c_o adder operands; add_sum_i, add_cy16_i adder results.
// Optional ALU_MUL_EARLY_EXIT_EN: finish as soon as no multiplier bits remain (B==0 skips RUN entirely).
module alu_mul_sequencer #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [15:0]  result_o,
  output logic         ovf_o,
  output logic [15:0]  add_high_o,
  output logic [7:0]   add_not_high_o,
  output logic [15:0]  add_low_o,
  output logic [7:0]   add_not_low_o,
  output logic         add_c_o,
  output logic         add_not_c_o,
  input  logic [15:0]  add_sum_i,
  input  logic         add_cy16_i
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  localparam logic [3:0] LAST = 4'(N - 1);
  state_t        state_q;
  logic [15:0]   p_q, m_q, result_q;
  logic [N-1:0]  q_q;
  logic [3:0]    cnt_q;
  logic          busy_q, done_q, ovf_q, run, last, accept;
  assign run    = state_q == S_RUN;
  assign accept = start_i && !run;
`ifdef ALU_MUL_EARLY_EXIT_EN
  assign last = (cnt_q == LAST) || ((q_q >> 1) == '0);
`else
  assign last = cnt_q == LAST;
`endif
  always_comb begin
    add_high_o     = run ? p_q : '0;
    add_low_o      = (run && q_q[0]) ? m_q : '0;
    add_c_o        = 1'b0;
    add_not_high_o = ~add_high_o[7:0];
    add_not_low_o  = ~add_low_o[7:0];
    add_not_c_o    = ~add_c_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      m_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      p_q   <= '0;
      m_q   <= 16'(a_i);
      q_q   <= b_i;
      cnt_q <= '0;
      ovf_q <= 1'b0;
`ifdef ALU_MUL_EARLY_EXIT_EN
      if (b_i == '0) begin
        state_q  <= S_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= '0;
      end else begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
`else
      state_q <= S_RUN;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`endif
    end else if (run) begin
      p_q   <= add_sum_i;
      m_q   <= m_q << 1;
      q_q   <= q_q >> 1;
      cnt_q <= cnt_q + 4'd1;
      ovf_q <= ovf_q | add_cy16_i;
      if (last) begin
        state_q  <= S_DONE;
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        result_q <= add_sum_i;
      end
    end else begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end
  end
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign ovf_o    = ovf_q;
  assign result_o = result_q;
endmodule
